uart_boot_loader: RTL
=====================

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, sets clock cycles per UART bit (12 MHz / 115200 baud).
REQ-002 Parameter MAX_WORDS, default 1024, sets the instruction-memory capacity in 32-bit words.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port uart_rx  input  1  serial line, 8N1, idle high, LSB first.
REQ-006 Port mem_we  output  1  one-cycle write strobe to instruction-memory load port.
REQ-007 Port mem_addr  output  32  byte address of the write, word-aligned.
REQ-008 Port mem_wdata  output  32  instruction word to write.
REQ-009 Port core_reset  output  1  reset driven into the processor top; high while loading.
REQ-010 Port done  output  1  image loaded successfully; sticky.
REQ-011 Port error  output  1  load failed; sticky.

Function
REQ-012 Stream format SHALL be: word count N (2 bytes, little-endian), then N*4 payload bytes, each word little-endian.
REQ-013 Receiver SHALL detect the start bit on a falling edge, confirm it low at CLKS_PER_BIT/2, then sample each data bit and the stop bit at intervals of CLKS_PER_BIT.
REQ-014 A low stop bit SHALL be a framing error and SHALL move the FSM to ERROR.
REQ-015 Receiver SHALL pulse rx_valid for one cycle with rx_byte once the stop-bit sample completes.
REQ-016 FSM states SHALL be LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR; reset state is LEN_LO.
REQ-017 Transitions: LEN_LO->LEN_HI on a byte; LEN_HI->DATA on a byte if 0<N<=MAX_WORDS, ->CHECK/DONE if N=0, ->ERROR if N>MAX_WORDS.
REQ-018 In DATA, bytes SHALL fill mem_wdata[7:0], [15:8], [23:16], [31:24] in order.
REQ-019 mem_we SHALL assert for exactly one cycle, the cycle after the 4th byte's rx_valid, with mem_addr = 4*word_index.
REQ-020 word_index SHALL start at 0 and increment after each write; after the N-th write the FSM SHALL leave DATA.
REQ-021 core_reset SHALL be 1 in every state except DONE and SHALL go low the cycle after DONE is entered.
REQ-022 done SHALL be 1 in DONE; error SHALL be 1 in ERROR; both states are absorbing until reset.
REQ-023 Bytes received in DONE or ERROR SHALL be ignored, with no mem_we.
REQ-024 mem_addr and mem_wdata SHALL hold their last values when mem_we is low.

Reset
REQ-025 On reset: state LEN_LO, mem_we 0, mem_addr 0, mem_wdata 0, core_reset 1, done 0, error 0, word_index 0, receiver idle.
REQ-026 Reset mid-byte or mid-image SHALL discard partial data; the next load restarts at address 0.

Configuration
REQ-027 With BOOT_CHECKSUM_EN defined, a trailing byte SHALL follow the payload; the FSM enters CHECK and goes to DONE if it equals the XOR of all payload bytes, else ERROR (N=0 expects 0x00).
REQ-028 Without BOOT_CHECKSUM_EN, CHECK SHALL NOT exist and the FSM SHALL go directly to DONE after the N-th write or after N=0.

Structure
REQ-029 Package boot_pkg SHALL hold the FSM state enum and the default CLKS_PER_BIT and MAX_WORDS constants.
REQ-030 Sub-module uart_rx (clk, reset, rx, rx_valid, rx_byte, frame_err) SHALL contain the bit-level receiver.

Verification
REQ-031 Bytes 01 00 13 05 50 00 -> one mem_we, addr 0x0, wdata 0x00500513; core_reset falls; done=1.
REQ-032 N=2 with words 0x00000013 and 0x00100093 -> writes at 0x0 and 0x4; mem_we high exactly 2 cycles total.
REQ-033 N=0x0401 with MAX_WORDS=1024 -> ERROR after LEN_HI; error=1, core_reset stays 1, no mem_we.
REQ-034 Byte with stop bit forced low -> error=1; subsequent valid bytes are ignored.
REQ-035 Reset asserted after 2 of 4 payload bytes, then a full 1-word image -> write at addr 0 with the new word only.
REQ-036 BOOT_CHECKSUM_EN, payload 13 05 50 00, checksum 0x46 -> done; checksum 0x47 -> error, core_reset stays 1.

Source files
------------

// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared FSM states and default parameters for the UART boot loader
// Defining BOOT_CHECKSUM_EN adds the CHECK state used for the trailing XOR byte.
package boot_pkg;

  localparam int BOOT_CLKS_PER_BIT = 104;
  localparam int BOOT_MAX_WORDS    = 1024;

  typedef enum logic [2:0] {
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
`ifdef BOOT_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE,
    ST_ERROR
  } boot_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 bit-level receiver, LSB first, mid-bit sampling
// Emits a one-cycle rx_valid for a good byte or frame_err for a low stop bit.
module uart_rx
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = BOOT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     r_state;
  logic [1:0]    r_sync;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte;
  logic          r_valid;
  logic          r_ferr;
  logic          w_rx;

  assign w_rx      = r_sync[1];
  assign rx_valid  = r_valid;
  assign rx_byte   = r_byte;
  assign frame_err = r_ferr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RX_IDLE;
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_prev  <= w_rx;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_prev && !w_rx) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          // a start bit that is high again at mid-bit was a glitch
          if (r_cnt == HALF) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (w_rx) begin
              r_valid <= 1'b1;
              r_byte  <= r_shift;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - loads a length-prefixed little-endian image from UART into instruction memory
// BOOT_CHECKSUM_EN: expect a trailing XOR-of-payload byte before declaring DONE.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = BOOT_CLKS_PER_BIT,
  parameter int MAX_WORDS    = BOOT_MAX_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  boot_state_t r_state;
  logic [7:0]  r_len_lo;
  logic [15:0] r_len;
  logic [15:0] r_word_index;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_acc;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_core_reset;
  logic        r_done;
  logic        r_error;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic        w_rx_valid;
  logic [7:0]  w_rx_byte;
  logic        w_frame_err;
  logic [15:0] w_len;

  assign w_len      = {w_rx_byte, r_len_lo};
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign core_reset = r_core_reset;
  assign done       = r_done;
  assign error      = r_error;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (uart_rx),
    .rx_valid  (w_rx_valid),
    .rx_byte   (w_rx_byte),
    .frame_err (w_frame_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_LEN_LO;
      r_len_lo     <= '0;
      r_len        <= '0;
      r_word_index <= '0;
      r_byte_idx   <= '0;
      r_acc        <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_mem_we     <= 1'b0;
      r_core_reset <= (r_state != ST_DONE);
      if (w_frame_err && r_state != ST_DONE && r_state != ST_ERROR) begin
        r_state <= ST_ERROR;
        r_error <= 1'b1;
      end else if (w_rx_valid) begin
        case (r_state)
          ST_LEN_LO: begin
            r_len_lo <= w_rx_byte;
            r_state  <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            r_len <= w_len;
            if ({1'b0, w_len} > MAX_N) begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end else if (w_len == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
              r_state <= ST_CHECK;
`else
              r_state <= ST_DONE;
              r_done  <= 1'b1;
`endif
            end else begin
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            // newest byte enters at the top so byte 0 ends in [7:0]
            r_acc      <= {w_rx_byte, r_acc[31:8]};
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            r_csum     <= r_csum ^ w_rx_byte;
`endif
            if (r_byte_idx == 2'd3) begin
              r_mem_we     <= 1'b1;
              r_mem_addr   <= {14'd0, r_word_index, 2'b00};
              r_mem_wdata  <= {w_rx_byte, r_acc[31:8]};
              r_word_index <= r_word_index + 16'd1;
              if (r_word_index == r_len - 16'd1) begin
`ifdef BOOT_CHECKSUM_EN
                r_state <= ST_CHECK;
`else
                r_state <= ST_DONE;
                r_done  <= 1'b1;
`endif
              end
            end
          end
`ifdef BOOT_CHECKSUM_EN
          ST_CHECK: begin
            if (w_rx_byte == r_csum) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
